// File: rtl/vga_capture_monitor.sv
// vga_capture_monitor
//   Receives hSync/vSync/RGB from the on-board VGA timing path, locks to the
//   configured raster timing (640x480@60 by default), recovers pixel
//   coordinates and reports per-frame colour statistics.
//   Optional feature macro: VGA_CAPTURE_CHECKSUM_EN
//     defined   -> per-frame mod-2^16 colour checksum on frameChecksum
//     undefined -> checksum logic removed, frameChecksum tied to zero
module vga_capture_monitor #(
  parameter int unsigned CLKS_PER_PIXEL = 4,
  parameter int unsigned SAMPLE_PHASE   = 2,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BP           = 48,
  parameter int unsigned H_ACT          = 640,
  parameter int unsigned H_TOTAL        = 800,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BP           = 33,
  parameter int unsigned V_ACT          = 480,
  parameter int unsigned V_TOTAL        = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic        locked,
  output logic        pixelValid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic [11:0] color,
  output logic        frameDone,
  output logic        frameUniform,
  output logic [11:0] frameColor,
  output logic [15:0] frameChecksum,
  output logic [7:0]  errorCount
);

  localparam int unsigned PH_W    = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned H_END   = H_START + H_ACT;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned V_END   = V_START + V_ACT;
  localparam logic [11:0] LINE_CLKS = 12'(H_TOTAL * CLKS_PER_PIXEL);

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

  logic            r_hs, r_hs_d, r_vs, r_vs_d;
  logic [11:0]     r_rgb;
  logic [PH_W-1:0] r_phase;
  logic [9:0]      r_hCount;
  logic [9:0]      r_vCount;
  logic [11:0]     r_lineClks;
  logic [11:0]     r_first;
  logic            r_uniform;
  state_t          r_state, w_next;

  logic w_hEdge, w_vEdge, w_tick, w_hActive, w_vActive, w_pixTick;
  logic w_lineBad, w_countGood, w_err, w_report;

  assign w_hEdge     = r_hs_d & ~r_hs;
  assign w_vEdge     = r_vs_d & ~r_vs;
  assign w_tick      = (r_phase == PH_W'(SAMPLE_PHASE));
  assign w_hActive   = (r_hCount >= 10'(H_START)) && (r_hCount < 10'(H_END));
  assign w_vActive   = (r_vCount >= 10'(V_START)) && (r_vCount < 10'(V_END));
  assign w_pixTick   = w_tick && w_hActive && w_vActive;
  assign w_lineBad   = w_hEdge && (r_lineClks != LINE_CLKS);
  assign w_countGood = (r_vCount == 10'(V_TOTAL - 1));

  // Register the syncs and colour once so all timing uses aligned copies
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs   <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs   <= 1'b0;
      r_vs_d <= 1'b0;
      r_rgb  <= '0;
    end else begin
      r_hs   <= hSync;
      r_hs_d <= r_hs;
      r_vs   <= vSync;
      r_vs_d <= r_vs;
      r_rgb  <= {VGA_R, VGA_G, VGA_B};
    end
  end

  // Raster position: pixel phase, column, row and line length measurement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase    <= '0;
      r_hCount   <= '0;
      r_vCount   <= '0;
      r_lineClks <= '0;
    end else begin
      if (w_hEdge || (r_phase == PH_W'(CLKS_PER_PIXEL - 1)))
        r_phase <= '0;
      else
        r_phase <= r_phase + 1'b1;

      if (w_hEdge)
        r_hCount <= '0;
      else if (w_tick && (r_hCount != '1))
        r_hCount <= r_hCount + 1'b1;

      // vSync edge wins over a coincident hSync edge: the row restarts at 0
      if (w_vEdge)
        r_vCount <= '0;
      else if (w_hEdge && (r_vCount != '1))
        r_vCount <= r_vCount + 1'b1;

      // Counts the edge cycle itself, so the value seen at the next edge is the line length
      if (w_hEdge)
        r_lineClks <= 12'd1;
      else if (r_lineClks != '1)
        r_lineClks <= r_lineClks + 1'b1;
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_SEARCH;
    else        r_state <= w_next;
  end

  // Lock FSM next state, error strobe and frame-report strobe
  always_comb begin
    w_next   = r_state;
    w_err    = 1'b0;
    w_report = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_vEdge) w_next = ST_MEASURE;
      end
      ST_MEASURE, ST_LOCKED: begin
        if (w_lineBad || (w_vEdge && !w_countGood)) begin
          w_next = ST_SEARCH;
          w_err  = 1'b1;
        end else if (w_vEdge) begin
          w_next   = ST_LOCKED;
          w_report = 1'b1;
        end
      end
      default: w_next = ST_SEARCH;
    endcase
  end

  // Lock flag and saturating timing-error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked     <= 1'b0;
      errorCount <= '0;
    end else begin
      locked <= (w_next == ST_LOCKED);
      if (w_err && (errorCount != 8'hFF))
        errorCount <= errorCount + 1'b1;
    end
  end

  // Per-pixel output strobe, only while locked
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixelValid <= 1'b0;
      x          <= '0;
      y          <= '0;
      color      <= '0;
    end else begin
      pixelValid <= w_pixTick && (r_state == ST_LOCKED);
      if (w_pixTick && (r_state == ST_LOCKED)) begin
        x     <= r_hCount - 10'(H_START);
        y     <= 9'(r_vCount - 10'(V_START));
        color <= r_rgb;
      end
    end
  end

  // Frame accumulators (first colour, uniformity) and report latching
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_first      <= '0;
      r_uniform    <= 1'b0;
      frameDone    <= 1'b0;
      frameUniform <= 1'b0;
      frameColor   <= '0;
    end else begin
      frameDone <= w_report;
      if (w_report) begin
        frameUniform <= r_uniform;
        frameColor   <= r_first;
      end
      if (w_vEdge) begin
        r_first   <= '0;
        r_uniform <= 1'b1;
      end else if (w_pixTick) begin
        if ((r_hCount == 10'(H_START)) && (r_vCount == 10'(V_START)))
          r_first <= r_rgb;
        else if (r_rgb != r_first)
          r_uniform <= 1'b0;
      end
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [15:0] r_sum;

  // Running colour sum, cleared at each vSync edge, latched on report
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum         <= '0;
      frameChecksum <= '0;
    end else begin
      if (w_vEdge)
        r_sum <= '0;
      else if (w_pixTick)
        r_sum <= r_sum + {4'h0, r_rgb};
      if (w_report)
        frameChecksum <= r_sum;
    end
  end
`else
  assign frameChecksum = '0;
`endif

endmodule
